// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and runs a single-outstanding
// request/response handshake to instruction memory, presenting NOP while waiting.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        fetch_wait
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        valid_q, valid_d;
  logic [31:0] redir_pc;

  assign redir_pc = redirect_pc & ~32'd3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
    end
  end

  // Redirect outranks stall; a request already accepted must still be
  // drained (DROP) before a new one may be issued.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = imem_ready ? S_DROP : S_REQ;
        end else if (imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          buf_d   = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end else if (!StallF) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_d = redir_pc;
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_HOLD);
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign PCF         = pc_q;
  assign PCPlus4F    = pc_q + 32'd4;
  assign fetch_wait  = ~valid_q;
  assign instruction = valid_q ? buf_q : NOP;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage pipeline. It owns the PC register and runs a single-outstanding request/response handshake to instruction memory. It drives `instruction`, `PCF` and `PCPlus4F` into the IF/ID pipeline register, and honours `StallF` and branch/jump redirects from Execute. When no valid instruction is available it presents a NOP and raises `fetch_wait` so the hazard unit can stall the front end.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset. Bits [1:0] must be 0.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `StallF` in 1: hold the current PC and the presented instruction.
- `redirect_valid` in 1: taken branch/jump from Execute (PCSrcE).
- `redirect_pc` in 32: redirect target (PCTargetE). Bits [1:0] are ignored and treated as 0.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, always equal to `PCF`.
- `imem_ready` in 1: request accepted this cycle (`imem_req` && `imem_ready`).
- `imem_rvalid` in 1: response data valid. Earliest one cycle after acceptance, exactly once per accepted request.
- `imem_rdata` in 32: response instruction word.
- `instruction` out 32: the buffered instruction when valid, otherwise NOP 32'h0000_0013.
- `PCF` out 32: PC of the instruction being fetched or presented.
- `PCPlus4F` out 32: `PCF` + 4, modulo 2^32.
- `fetch_wait` out 1: high whenever `instruction` is not a valid fetched word.

## Operation
- The FSM has five states: IDLE, REQ, WAIT, HOLD, DROP. All state, `PCF`, the instruction buffer and the valid flag are registers.
- Outputs decode from state:
  - `imem_req` = (state == REQ).
  - `fetch_wait` = (state != HOLD).
  - `instruction` = buffer when in HOLD, else NOP.
- **IDLE:** go to REQ on the next edge unconditionally.
- **REQ:** `imem_req` = 1 with `imem_addr` = `PCF`.
  - If `imem_ready`: go to WAIT.
  - Otherwise stay in REQ. `PCF` may change while in REQ without acceptance; memory must sample the address only on acceptance.
- **WAIT:** on `imem_rvalid`, latch `imem_rdata` into the buffer and go to HOLD.
- **HOLD:** the instruction is valid.
  - If `StallF` = 0: `PCF` <= `PCF` + 4 and go to REQ.
  - If `StallF` = 1: stay, with `PCF` and `instruction` unchanged.
- **DROP:** wait for the response of a cancelled request. On `imem_rvalid`, discard the data and go to REQ.
- **Redirect** (`redirect_valid` = 1) has priority over `StallF`. It sets `PCF` <= {`redirect_pc`[31:2], 2'b00} in every state except IDLE, plus a state change:
  - REQ without `imem_ready`: go to REQ. The new address is presented next cycle.
  - REQ with `imem_ready`: the old address was accepted, so go to DROP.
  - WAIT without `imem_rvalid`: go to DROP.
  - WAIT with `imem_rvalid`: data is discarded, go to REQ.
  - HOLD: the buffer is invalidated, go to REQ, regardless of `StallF`.
  - DROP without `imem_rvalid`: stay in DROP. A later redirect overwrites `PCF` again.
  - DROP with `imem_rvalid`: go to REQ.
- Redirect is ignored in IDLE. Execute cannot issue one then.
- `PCPlus4F` is combinational from `PCF`. At 32'hFFFF_FFFC it wraps to 32'h0000_0000, and sequential advance wraps the same way.
- There is never more than one outstanding request, and no new request is issued until the previous response has been consumed or dropped.

## Timing
- **Reset** (async assert; state is held while `rst` is high):
  - state = IDLE, `PCF` = `RESET_PC`, `PCPlus4F` = `RESET_PC` + 4.
  - `imem_req` = 0, `instruction` = 32'h0000_0013, `fetch_wait` = 1, buffer = 0.
- **First cycle after release:** IDLE. `imem_req` rises one edge later.
- **Best-case latency:** REQ accepted in cycle n → WAIT in n+1 with `rvalid` → HOLD in n+2. So the instruction is valid 2 cycles after acceptance, and back-to-back throughput is 1 instruction per 3 cycles.
- **Reset mid-operation:** any outstanding request is abandoned. Memory must also be reset by the same `rst`.
- **Simultaneous events:**
  - `redirect_valid` with `StallF` in HOLD: the redirect wins.
  - `imem_rvalid` in REQ or HOLD is a protocol violation and is ignored.

## Test plan
- **Reset/boot:** `RESET_PC` = 32'h100, memory with `ready` always 1 and 1-cycle `rvalid`, `StallF` = 0 → `imem_addr` sequence 100, 104, 108. `instruction` is valid every 3rd cycle with the matching words, and NOP with `fetch_wait` = 1 otherwise.
- **Stall:** `StallF` = 1 for 4 cycles while in HOLD at `PCF` = 32'h104 → `PCF`, `PCPlus4F` (32'h108) and `instruction` are stable, `imem_req` = 0. Releasing the stall gives `imem_addr` = 32'h108 next cycle.
- **Redirect in HOLD with stall:** `redirect_valid` = 1, `redirect_pc` = 32'h2003, `StallF` = 1 → next cycle `PCF` = 32'h2000, `fetch_wait` = 1, `imem_req` = 1.
- **Redirect during WAIT:** `rvalid` delayed 3 cycles, redirect to 32'h400 in the first WAIT cycle → the late response is discarded (DROP), `instruction` stays NOP, and the next accepted request has `imem_addr` = 32'h400.
- **Back-pressure:** `imem_ready` = 0 for 5 cycles → `imem_req` is held at 1 with a stable address. A redirect to 32'h800 during this window changes `imem_addr` to 32'h800 before acceptance, and no DROP occurs.
- **Wrap:** redirect to 32'hFFFF_FFFC → `PCPlus4F` = 32'h0, and after advance `PCF` = 32'h0.
